// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: HD44780 16x2 write sequencer with two-port round-robin bus sharing.
// Define LCD_INIT_SEQ_EN to include the power-up wait and the built-in init command sequence.
module lcd_bus_arbiter #(
    parameter int unsigned T_PWRUP      = 750000,
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_EHIGH      = 16,
    parameter int unsigned T_CMD_WAIT   = 2500,
    parameter int unsigned T_CLEAR_WAIT = 82000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iREQ0,
    input  logic       iREQ1,
    input  logic       iRS0,
    input  logic       iRS1,
    input  logic [7:0] iDATA0,
    input  logic [7:0] iDATA1,
    output logic       oACK0,
    output logic       oACK1,
    output logic       oREADY,
    output logic       oBUSY,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oLCD_E
);

    localparam int unsigned DW      = 8;
    localparam int unsigned T_MAX_0 = (T_PWRUP > T_CLEAR_WAIT) ? T_PWRUP : T_CLEAR_WAIT;
    localparam int unsigned T_MAX_1 = (T_CMD_WAIT > T_EHIGH) ? T_CMD_WAIT : T_EHIGH;
    localparam int unsigned T_MAX_2 = (T_MAX_1 > T_SETUP) ? T_MAX_1 : T_SETUP;
    localparam int unsigned T_MAX   = (T_MAX_0 > T_MAX_2) ? T_MAX_0 : T_MAX_2;
    localparam int unsigned CW      = $clog2(T_MAX) + 1;

    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_SETUP = 3'd3;
    localparam logic [2:0] S_EHIGH = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
`ifdef LCD_INIT_SEQ_EN
    localparam logic [2:0]    S_PWRUP   = 3'd0;
    localparam logic [2:0]    S_INIT    = 3'd1;
    localparam logic [2:0]    S_RESET   = S_PWRUP;
    localparam logic [CW-1:0] CNT_RESET = CW'(T_PWRUP);
`else
    localparam logic [2:0]    S_RESET   = S_IDLE;
    localparam logic [CW-1:0] CNT_RESET = '0;
`endif

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_ready;
    logic          r_busy;
    logic          r_lcd_e;
    logic          r_lcd_rs;
    logic [DW-1:0] r_lcd_data;
    logic          r_last;

    logic [2:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_ack0_nxt;
    logic          w_ack1_nxt;
    logic          w_ready_nxt;
    logic          w_busy_nxt;
    logic          w_e_nxt;
    logic          w_rs_nxt;
    logic [DW-1:0] w_data_nxt;
    logic          w_last_nxt;
    logic          w_pick0;
    logic          w_pick1;
    logic          w_long_wait;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0] r_init_idx;
    logic [2:0] w_init_idx_nxt;

    function automatic logic [DW-1:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction
`endif

    // r_last = 1 means port 1 was granted last, so port 0 wins a tie
    assign w_pick1 = iREQ1 & (~iREQ0 | ~r_last);
    assign w_pick0 = iREQ0 & ~w_pick1;

    // Clear display / return home need the long execution delay
    assign w_long_wait = ~r_lcd_rs & (r_lcd_data[7:2] == 6'd0) & (r_lcd_data != 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_ready_nxt = r_ready;
        w_busy_nxt  = r_busy;
        w_e_nxt     = r_lcd_e;
        w_rs_nxt    = r_lcd_rs;
        w_data_nxt  = r_lcd_data;
        w_last_nxt  = r_last;
`ifdef LCD_INIT_SEQ_EN
        w_init_idx_nxt = r_init_idx;
`endif
        case (r_state)
`ifdef LCD_INIT_SEQ_EN
            S_PWRUP: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_INIT: begin
                w_rs_nxt       = 1'b0;
                w_data_nxt     = init_cmd(r_init_idx[1:0]);
                w_init_idx_nxt = r_init_idx + 3'd1;
                w_state_nxt    = S_SETUP;
                w_cnt_nxt      = CW'(T_SETUP);
            end
`endif
            S_IDLE: begin
                if (r_ready) begin
                    if (w_pick0 | w_pick1) begin
                        w_ack0_nxt  = w_pick0;
                        w_ack1_nxt  = w_pick1;
                        w_rs_nxt    = w_pick1 ? iRS1 : iRS0;
                        w_data_nxt  = w_pick1 ? iDATA1 : iDATA0;
                        w_last_nxt  = w_pick1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = CW'(T_SETUP);
                    end
                end else begin
                    // Only reachable straight out of reset when the init sequence is absent
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_SETUP: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = S_EHIGH;
                    w_e_nxt     = 1'b1;
                    w_cnt_nxt   = CW'(T_EHIGH);
                end
            end
            S_EHIGH: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = S_WAIT;
                    w_e_nxt     = 1'b0;
                    w_cnt_nxt   = w_long_wait ? CW'(T_CLEAR_WAIT) : CW'(T_CMD_WAIT);
                end
            end
            S_WAIT: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
`ifdef LCD_INIT_SEQ_EN
                    if (!r_ready) begin
                        if (r_init_idx == 3'd4) begin
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_INIT;
                            w_busy_nxt  = 1'b1;
                        end
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = S_RESET;
                w_cnt_nxt   = CNT_RESET;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= S_RESET;
            r_cnt      <= CNT_RESET;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= '0;
            r_last     <= 1'b1;
`ifdef LCD_INIT_SEQ_EN
            r_init_idx <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ack0     <= w_ack0_nxt;
            r_ack1     <= w_ack1_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_lcd_e    <= w_e_nxt;
            r_lcd_rs   <= w_rs_nxt;
            r_lcd_data <= w_data_nxt;
            r_last     <= w_last_nxt;
`ifdef LCD_INIT_SEQ_EN
            r_init_idx <= w_init_idx_nxt;
`endif
        end
    end

    assign oACK0     = r_ack0;
    assign oACK1     = r_ack1;
    assign oREADY    = r_ready;
    assign oBUSY     = r_busy;
    assign oLCD_DATA = r_lcd_data;
    assign oLCD_RS   = r_lcd_rs;
    assign oLCD_RW   = 1'b0;
    assign oLCD_E    = r_lcd_e;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed bench for lcd_bus_arbiter with short timing parameters.
// Expected init timing depends on whether LCD_INIT_SEQ_EN is defined for the build.
module tb_lcd_bus_arbiter;

    localparam int unsigned P_PWRUP = 20;
    localparam int unsigned P_SETUP = 2;
    localparam int unsigned P_EHIGH = 4;
    localparam int unsigned P_CMD   = 10;
    localparam int unsigned P_CLR   = 30;
`ifdef LCD_INIT_SEQ_EN
    localparam int EXP_NRISE = 4;
    localparam int EXP_READY = 108;
`else
    localparam int EXP_NRISE = 0;
    localparam int EXP_READY = 1;
`endif

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iREQ0 = 1'b0, iREQ1 = 1'b0;
    logic       iRS0 = 1'b0, iRS1 = 1'b0;
    logic [7:0] iDATA0 = 8'h00, iDATA1 = 8'h00;
    logic       oACK0, oACK1, oREADY, oBUSY, oLCD_RS, oLCD_RW, oLCD_E;
    logic [7:0] oLCD_DATA;

    int n_tests = 0;
    int n_fail  = 0;

    int         rise_c[4];
    int         fall_c[4];
    logic [7:0] rise_d[4];
    logic       rise_rs[4];
    int         exp_rise[4] = '{23, 40, 57, 94};
    logic [7:0] exp_cmd[4]  = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_bus_arbiter #(
        .T_PWRUP(P_PWRUP), .T_SETUP(P_SETUP), .T_EHIGH(P_EHIGH),
        .T_CMD_WAIT(P_CMD), .T_CLEAR_WAIT(P_CLR)
    ) u_dut (
        .iCLK(iCLK), .iRST(iRST),
        .iREQ0(iREQ0), .iREQ1(iREQ1), .iRS0(iRS0), .iRS1(iRS1),
        .iDATA0(iDATA0), .iDATA1(iDATA1),
        .oACK0(oACK0), .oACK1(oACK1), .oREADY(oREADY), .oBUSY(oBUSY),
        .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW), .oLCD_E(oLCD_E)
    );

    always #5 iCLK = ~iCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            if (!oBUSY) break;
            tick();
        end
        check_eq("idle_reached", 32'(oBUSY), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_e"},     32'(oLCD_E),    32'd0);
        check_eq({tag, "_rs"},    32'(oLCD_RS),   32'd0);
        check_eq({tag, "_data"},  32'(oLCD_DATA), 32'd0);
        check_eq({tag, "_rw"},    32'(oLCD_RW),   32'd0);
        check_eq({tag, "_ack0"},  32'(oACK0),     32'd0);
        check_eq({tag, "_ack1"},  32'(oACK1),     32'd0);
        check_eq({tag, "_ready"}, 32'(oREADY),    32'd0);
        check_eq({tag, "_busy"},  32'(oBUSY),     32'd1);
    endtask

    // Release reset with requests already held, follow init until the first ack
    task automatic run_init(input int exp_port, input logic [7:0] exp_data, input logic exp_rs);
        int   nr, nf, rdy_c, ack_c, port;
        logic pe, busy_at_rdy;
        nr = 0; nf = 0; rdy_c = -1; ack_c = -1; port = -1; pe = 1'b0; busy_at_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rise_c[i] = 0; fall_c[i] = 0; rise_d[i] = 8'h00; rise_rs[i] = 1'b1;
        end
        iRST = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (oLCD_E && !pe) begin
                if (nr < 4) begin
                    rise_c[nr] = k; rise_d[nr] = oLCD_DATA; rise_rs[nr] = oLCD_RS;
                end
                nr++;
            end
            if (!oLCD_E && pe && nf < 4) begin
                fall_c[nf] = k;
                nf++;
            end
            pe = oLCD_E;
            if (oREADY && rdy_c < 0) begin
                rdy_c = k;
                busy_at_rdy = oBUSY;
            end
            if (oACK0 || oACK1) begin
                ack_c = k;
                port  = (oACK0 && oACK1) ? 2 : (oACK1 ? 1 : 0);
                break;
            end
        end
        check_eq("init_nrise", 32'(nr), 32'(EXP_NRISE));
        for (int i = 0; i < EXP_NRISE; i++) begin
            check_eq($sformatf("init_rise%0d_cyc", i), 32'(rise_c[i]), 32'(exp_rise[i]));
            check_eq($sformatf("init_rise%0d_data", i), 32'(rise_d[i]), 32'(exp_cmd[i]));
            check_eq($sformatf("init_rise%0d_rs", i), 32'(rise_rs[i]), 32'd0);
            check_eq($sformatf("init_e%0d_width", i), 32'(fall_c[i] - rise_c[i]), 32'(P_EHIGH));
        end
        check_eq("init_ready_cyc", 32'(rdy_c), 32'(EXP_READY));
        check_eq("init_busy_at_ready", 32'(busy_at_rdy), 32'd0);
        check_eq("init_first_ack_cyc", 32'(ack_c), 32'(EXP_READY + 1));
        check_eq("init_first_ack_port", 32'(port), 32'(exp_port));
        check_eq("init_first_data", 32'(oLCD_DATA), 32'(exp_data));
        check_eq("init_first_rs", 32'(oLCD_RS), 32'(exp_rs));
        check_eq("init_busy_on_ack", 32'(oBUSY), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ack0_h, ack1_h, e_h, busy_h;
        int          ok_n, na0, na1, nr, nf, nacks;
        int          r[3], f[3], acyc[4], aport[4];
        logic [7:0]  rd[3], adata[4];
        logic        rrs[3], pe;

        // Reset values
        repeat (3) tick();
        check_reset_outputs("reset");

        // Init with port 1 requesting from reset release
        iREQ1 = 1'b1; iRS1 = 1'b1; iDATA1 = 8'h55;
        run_init(1, 8'h55, 1'b1);
        iREQ1 = 1'b0;
        wait_idle();

        // Single data write on port 0
        ack0_h = '0; ack1_h = '0; e_h = '0; busy_h = '0; ok_n = 0;
        iREQ0 = 1'b1; iRS0 = 1'b1; iDATA0 = 8'h41;
        for (int j = 1; j <= 20; j++) begin
            tick();
            ack0_h[j] = oACK0; ack1_h[j] = oACK1; e_h[j] = oLCD_E; busy_h[j] = oBUSY;
            if (oLCD_RS && oLCD_DATA == 8'h41) ok_n++;
            if (oACK0) iREQ0 = 1'b0;
        end
        check_eq("single_ack0", ack0_h, 32'h0000_0002);
        check_eq("single_ack1", ack1_h, 32'h0000_0000);
        check_eq("single_e",    e_h,    32'h0000_0078);
        check_eq("single_busy", busy_h, 32'h0001_FFFE);
        check_eq("single_rs_data_stable", 32'(ok_n), 32'd20);

        // Back-to-back on port 1: clear (long wait), then two data writes
        nr = 0; nf = 0; na0 = 0; na1 = 0; pe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r[i] = 0; f[i] = 0; rd[i] = 8'h00; rrs[i] = 1'b0;
        end
        iREQ1 = 1'b1; iRS1 = 1'b0; iDATA1 = 8'h01;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (oLCD_E && !pe && nr < 3) begin
                r[nr] = k; rd[nr] = oLCD_DATA; rrs[nr] = oLCD_RS; nr++;
            end
            if (!oLCD_E && pe && nf < 3) begin
                f[nf] = k; nf++;
            end
            pe = oLCD_E;
            if (oACK0) na0++;
            if (oACK1) begin
                na1++;
                if (na1 == 1) iRS1 = 1'b1;
                if (na1 == 2) iDATA1 = 8'h02;
                if (na1 == 3) iREQ1 = 1'b0;
            end
            if (nf == 3) break;
        end
        iREQ1 = 1'b0;
        check_eq("long_first_rs",   32'(rrs[0]), 32'd0);
        check_eq("long_first_data", 32'(rd[0]), 32'h01);
        check_eq("long_e_width",    32'(f[0] - r[0]), 32'(P_EHIGH));
        check_eq("long_gap_clear",  32'(r[1] - f[0]), 32'(P_CLR + 1 + P_SETUP));
        check_eq("long_second_rs",  32'(rrs[1]), 32'd1);
        check_eq("long_gap_data",   32'(r[2] - f[1]), 32'(P_CMD + 1 + P_SETUP));
        check_eq("long_third_data", 32'(rd[2]), 32'h02);
        check_eq("long_ack1_count", 32'(na1), 32'd3);
        check_eq("long_ack0_count", 32'(na0), 32'd0);
        wait_idle();

        // Contention: both ports held, last grant was port 1
        nacks = 0;
        for (int i = 0; i < 4; i++) begin
            acyc[i] = 0; aport[i] = -1; adata[i] = 8'h00;
        end
        iREQ0 = 1'b1; iRS0 = 1'b1; iDATA0 = 8'hA0;
        iREQ1 = 1'b1; iRS1 = 1'b1; iDATA1 = 8'hB1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (oACK0 || oACK1) begin
                acyc[nacks]  = k;
                aport[nacks] = (oACK0 && oACK1) ? 2 : (oACK1 ? 1 : 0);
                adata[nacks] = oLCD_DATA;
                nacks++;
                if (nacks == 4) break;
            end
        end
        iREQ0 = 1'b0; iREQ1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rr_port%0d", i), 32'(aport[i]), 32'(i % 2));
            check_eq($sformatf("rr_data%0d", i), 32'(adata[i]), (i % 2 == 0) ? 32'hA0 : 32'hB1);
        end
        check_eq("rr_period01", 32'(acyc[1] - acyc[0]), 32'(1 + P_SETUP + P_EHIGH + P_CMD));
        check_eq("rr_period12", 32'(acyc[2] - acyc[1]), 32'(1 + P_SETUP + P_EHIGH + P_CMD));
        wait_idle();

        // Reset while E is high
        iREQ0 = 1'b1; iRS0 = 1'b1; iDATA0 = 8'h77;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (oACK0) iREQ0 = 1'b0;
            if (oLCD_E) break;
        end
        iREQ0 = 1'b0;
        check_eq("midrst_e_before", 32'(oLCD_E), 32'd1);
        iRST = 1'b1;
        tick();
        check_reset_outputs("midrst");
        tick();
        tick();

        // Init repeats; both ports held, pointer back to port 0
        iREQ0 = 1'b1; iRS0 = 1'b0; iDATA0 = 8'h12;
        iREQ1 = 1'b1; iRS1 = 1'b1; iDATA1 = 8'h34;
        run_init(0, 8'h12, 1'b0);
        iREQ0 = 1'b0; iREQ1 = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
